// File: rtl/addr_seq_pkg.sv
// Shared constants for the effective-address sequencer: addressing modes,
// ALU op codes and the sequencer state encoding.
package addr_seq_pkg;

    localparam logic [1:0] MODE_ABS = 2'd0;
    localparam logic [1:0] MODE_ZP  = 2'd1;
    localparam logic [1:0] MODE_REL = 2'd2;

    localparam logic [3:0] ALU_OP_ADC = 4'h0;
    localparam logic [3:0] ALU_OP_NOP = 4'hF;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LO   = 2'd1,
        ST_HI   = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Reserved mode 3 behaves exactly like absolute indexed.
    function automatic logic [1:0] norm_mode(input logic [1:0] m);
        return (m == 2'd3) ? MODE_ABS : m;
    endfunction

endpackage

// File: rtl/addr_sequencer.sv
// Effective-address sequencer: low-byte add, optional high-byte add on the shared ALU.
// Optional feature macro: ADDR_SEQ_PAGE_SKIP_EN (skip the high-byte cycle when no page is crossed).
module addr_sequencer
    import addr_seq_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  mode,
    input  logic [15:0] base,
    input  logic [7:0]  index,
    output logic        busy,
    output logic        done,
    output logic [15:0] addr,
    output logic        page_cross,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic        alu_carry_in,
    output logic [3:0]  alu_op,
    input  logic [8:0]  alu_f
);

    state_t      state_q, state_d;
    logic [7:0]  base_hi_q, base_hi_d;
    logic        idx_neg_q, idx_neg_d;
    logic [1:0]  mode_q, mode_d;
    logic [7:0]  lo_q, lo_d;
    logic        cross_q, cross_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] addr_q, addr_d;
    logic        page_cross_q, page_cross_d;
    logic [7:0]  alu_a_q, alu_a_d;
    logic [7:0]  alu_b_q, alu_b_d;
    logic        alu_cin_q, alu_cin_d;
    logic [3:0]  alu_op_q, alu_op_d;
    logic        cross_lo;

    // Page crossing is fully determined by the low-byte carry and the offset sign.
    always_comb begin
        cross_lo = 1'b0;
        unique case (mode_q)
            MODE_REL: cross_lo = alu_f[8] ^ idx_neg_q;
            MODE_ZP:  cross_lo = 1'b0;
            default:  cross_lo = alu_f[8];
        endcase
    end

    always_comb begin
        state_d      = state_q;
        base_hi_d    = base_hi_q;
        idx_neg_d    = idx_neg_q;
        mode_d       = mode_q;
        lo_d         = lo_q;
        cross_d      = cross_q;
        addr_d       = addr_q;
        page_cross_d = page_cross_q;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        alu_a_d      = 8'h00;
        alu_b_d      = 8'h00;
        alu_cin_d    = 1'b0;
        alu_op_d     = ALU_OP_NOP;

        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d   = ST_LO;
                    base_hi_d = base[15:8];
                    idx_neg_d = index[7];
                    mode_d    = norm_mode(mode);
                    busy_d    = 1'b1;
                    alu_a_d   = base[7:0];
                    alu_b_d   = index;
                    alu_op_d  = ALU_OP_ADC;
                end
            end
            ST_LO: begin
                lo_d    = alu_f[7:0];
                cross_d = cross_lo;
                if (mode_q == MODE_ZP) begin
                    state_d      = ST_DONE;
                    done_d       = 1'b1;
                    addr_d       = {8'h00, alu_f[7:0]};
                    page_cross_d = 1'b0;
                end
`ifdef ADDR_SEQ_PAGE_SKIP_EN
                else if (!cross_lo) begin
                    state_d      = ST_DONE;
                    done_d       = 1'b1;
                    addr_d       = {base_hi_q, alu_f[7:0]};
                    page_cross_d = 1'b0;
                end
`endif
                else begin
                    state_d   = ST_HI;
                    busy_d    = 1'b1;
                    alu_a_d   = base_hi_q;
                    alu_b_d   = (mode_q == MODE_REL && idx_neg_q) ? 8'hFF : 8'h00;
                    alu_cin_d = alu_f[8];
                    alu_op_d  = ALU_OP_ADC;
                end
            end
            ST_HI: begin
                // Carry-out of the high byte is dropped so the address wraps at 16'hFFFF.
                state_d      = ST_DONE;
                done_d       = 1'b1;
                addr_d       = {alu_f[7:0], lo_q};
                page_cross_d = cross_q;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            base_hi_q    <= 8'h00;
            idx_neg_q    <= 1'b0;
            mode_q       <= MODE_ABS;
            lo_q         <= 8'h00;
            cross_q      <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            addr_q       <= 16'h0000;
            page_cross_q <= 1'b0;
            alu_a_q      <= 8'h00;
            alu_b_q      <= 8'h00;
            alu_cin_q    <= 1'b0;
            alu_op_q     <= ALU_OP_NOP;
        end else begin
            state_q      <= state_d;
            base_hi_q    <= base_hi_d;
            idx_neg_q    <= idx_neg_d;
            mode_q       <= mode_d;
            lo_q         <= lo_d;
            cross_q      <= cross_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            addr_q       <= addr_d;
            page_cross_q <= page_cross_d;
            alu_a_q      <= alu_a_d;
            alu_b_q      <= alu_b_d;
            alu_cin_q    <= alu_cin_d;
            alu_op_q     <= alu_op_d;
        end
    end

    assign busy         = busy_q;
    assign done         = done_q;
    assign addr         = addr_q;
    assign page_cross   = page_cross_q;
    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_carry_in = alu_cin_q;
    assign alu_op       = alu_op_q;

endmodule

// File: doc/addr_sequencer.md
# addr_sequencer

Multi-cycle effective-address sequencer that drives the shared 8-bit `ALU` to form 16-bit addresses for indexed and relative addressing modes. It performs a low-byte add, then an optional high-byte add carrying the low-byte carry-out, and reports page crossings. The block sits between instruction decode, which issues `start`, and the bus interface, which consumes `addr` on `done`. It owns the ALU operand, op and carry inputs whenever it is busy.

## Interface
- No parameters.
- `clk` in 1: sole clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request. Sampled only in IDLE.
- `mode` in 2: `0` absolute indexed, `1` zero-page indexed, `2` relative with a signed offset. `3` is reserved and is treated as `0`.
- `base` in 16: base address, captured on accept.
- `index` in 8: index register value or branch offset, captured on accept.
- `busy` out 1: high in LO and HI.
- `done` out 1: one-cycle pulse; `addr` and `page_cross` are valid from this cycle on.
- `addr` out 16: effective address; held until the next `done`.
- `page_cross` out 1: the high byte of the result differs from `base[15:8]`; held with `addr`.
- `alu_a` out 8, `alu_b` out 8, `alu_carry_in` out 1, `alu_op` out 4: ALU drive.
- `alu_f` in 9: ALU result; bit 8 is carry-out.

## Operation
- States: IDLE, LO, HI, DONE.
- **IDLE → LO** when `start` is high. Capture `base`, `index` and `mode`.
- **LO:** drive `alu_a = base[7:0]`, `alu_b = index`, `alu_carry_in = 0`, `alu_op = 4'h0` (add with carry).
  - On the edge, latch `lo = alu_f[7:0]` and `c = alu_f[8]`.
- **Page-cross rule:**
  - Absolute: cross = `c`.
  - Relative: cross = `c ^ index[7]`.
  - Zero-page: cross = 0.
- **Leaving LO:**
  - Zero-page: result is `{8'h00, lo}`, which wraps within page 0. Go to DONE.
  - Otherwise: go to HI (see Configuration for the skip case).
- **HI:** drive `alu_a = base[15:8]` and `alu_carry_in = c`, with `alu_op = 4'h0`.
  - `alu_b` is `8'hFF` for relative with `index[7] = 1`, and `8'h00` otherwise.
  - On the edge, result is `{alu_f[7:0], lo}`. Discard `alu_f[8]`, so the result wraps at `16'hFFFF`. Go to DONE.
- **DONE:** `done = 1` for this cycle. Update `addr` and `page_cross`. Return to IDLE.
- **Not busy:** when not in LO or HI, drive `alu_op = 4'hF` (pass-through) and `alu_a = alu_b = 0`, `alu_carry_in = 0`.
- **`start` outside IDLE:** ignored; the upstream block must hold or re-issue it.

## Timing
- Reset values: IDLE; `busy = 0`, `done = 0`, `addr = 16'h0000`, `page_cross = 0`; ALU drive at its not-busy values.
- `start` sampled at edge k:
  - LO during cycle k+1.
  - HI during cycle k+2 when executed.
  - `done` at k+3 with HI, or k+2 without HI.
- The ALU is combinational, so its result is captured on the same edge that ends LO or HI.
- Minimum spacing between accepted requests: 4 cycles with HI, 3 without.
- `reset` in any state returns to IDLE with reset values on the next edge. An in-flight result is dropped and `done` is not pulsed.

## Configuration
- `ADDR_SEQ_PAGE_SKIP_EN` **defined:** in absolute or relative mode, if cross = 0, skip HI.
  - Result is `{base[15:8], lo}`; go straight to DONE.
  - Latency is 2 cycles.
- **Undefined:** HI always executes for absolute and relative. Fixed 3-cycle latency, matching the 6502 dummy-cycle timing.
- Both builds produce identical `addr` and `page_cross` values.

## Structure
- Package `addr_seq_pkg` holds:
  - mode constants (`MODE_ABS`, `MODE_ZP`, `MODE_REL`);
  - the state enum;
  - ALU op constants (`ALU_OP_ADC = 4'h0`, `ALU_OP_NOP = 4'hF`).
- No sub-module. The testbench instantiates `ALU` alongside and connects `alu_f` back to the block.

## Test plan
- **Absolute with page cross:** `base = 16'h12F0`, `index = 8'h20` → `addr = 16'h1310`, `page_cross = 1`, `done` 3 cycles after `start` in both builds.
- **Zero-page wrap:** `base = 16'h00F0`, `index = 8'h20` → `addr = 16'h0010`, `page_cross = 0`, `done` 2 cycles after `start`, and `alu_op` is never `4'h0` in the cycle after LO.
- **Relative, no cross:** `base = 16'h1205`, `index = 8'hFB` → `addr = 16'h1200`, `page_cross = 0`.
  - Latency is 2 cycles with `ADDR_SEQ_PAGE_SKIP_EN`, 3 without.
- **Relative, backward cross:** `base = 16'h1202`, `index = 8'hFB` → `addr = 16'h11FD`, `page_cross = 1`.
- **Top-of-memory wrap:** absolute, `base = 16'hFFFF`, `index = 8'h01` → `addr = 16'h0000`, `page_cross = 1`.
- **`start` while busy, and reset mid-operation:**
  - A second `start` raised during LO is ignored.
  - `reset` asserted in HI → IDLE next cycle, no `done`, `addr = 16'h0000`.
